// File: rtl/adc_pkg.sv
// Shared types and timing defaults for the serial ADC reader and its digit splitter.
package adc_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_SETUP,
    S_SHIFT,
    S_CALC,
    S_SPLIT,
    S_DONE
  } state_t;

  localparam int unsigned SAMPLE_CYCLES_DEF = 50_000;
  localparam int unsigned SETUP_CYCLES_DEF  = 100;
  localparam int unsigned HALF_CYCLES_DEF   = 25;
  localparam int unsigned VREF_TENTHS_DEF   = 50;

  localparam int unsigned VREF_TENTHS_MIN = 1;
  localparam int unsigned VREF_TENTHS_MAX = 99;

  localparam int unsigned SPLIT_MAX_ITER = 9;
  localparam logic [6:0]  DIGIT_BASE     = 7'd10;

  // 17 us of ADC conversion time, counted in serial half-periods (0.5 us each).
  localparam int unsigned CONV_HALVES = 34;

  function automatic int unsigned txn_cycles(input int unsigned setup, input int unsigned half);
    return 1 + setup + 16 * half + 1 + (SPLIT_MAX_ITER + 1) + 1;
  endfunction

endpackage

// File: rtl/adc_serial_reader_if.sv
// Board-level pins of a TLC549-class serial ADC.
interface adc_serial_reader_if;
  logic ADC_DATA;
  logic ADC_CS_N;
  logic ADC_CLK;

  modport master (input ADC_DATA, output ADC_CS_N, output ADC_CLK);
  modport slave  (output ADC_DATA, input ADC_CS_N, input ADC_CLK);
endinterface

// File: rtl/adc_tenths_split.sv
// Sequential divide-by-10 of a tenths-of-a-volt value into integer and tenths digits.
module adc_tenths_split
  import adc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] tenths,
  output logic [3:0] quot,
  output logic [3:0] rem,
  output logic       done
);

  logic [6:0] rem_q;
  logic [3:0] quot_q;
  logic       busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      rem_q  <= tenths;
      quot_q <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      if (rem_q >= DIGIT_BASE) begin
        rem_q  <= rem_q - DIGIT_BASE;
        quot_q <= quot_q + 4'd1;
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign done = busy && (rem_q < DIGIT_BASE);
  assign quot = quot_q;
  assign rem  = rem_q[3:0];

endmodule

// File: rtl/adc_serial_reader.sv
// Periodic 8-bit read of a serial ADC, scaled to tenths of a volt and split into
// display digits that hold until the next completed sample.
//   state   | meaning
//   S_WAIT  | idle, CS high, waiting for the period tick
//   S_SETUP | CS low, serial clock parked low before the first bit
//   S_SHIFT | 8 serial bits, data captured on each ADC_CLK rise
//   S_CALC  | scale code to tenths, start the digit split
//   S_SPLIT | repeated subtract-10 until remainder < 10
//   S_DONE  | outputs updated, o_valid high
module adc_serial_reader
  import adc_pkg::*;
#(
  parameter int unsigned SAMPLE_CYCLES = SAMPLE_CYCLES_DEF,
  parameter int unsigned SETUP_CYCLES  = SETUP_CYCLES_DEF,
  parameter int unsigned HALF_CYCLES   = HALF_CYCLES_DEF,
  parameter int unsigned VREF_TENTHS   = VREF_TENTHS_DEF
) (
  input  logic                CLK_50M,
  input  logic                RST_N,
  adc_serial_reader_if.master adc,
  output logic [7:0]          o_code,
  output logic [3:0]          o_vol_int,
  output logic [3:0]          o_vol_dec,
  output logic                o_valid
);

  localparam int unsigned PCNT_W      = $clog2(SAMPLE_CYCLES);
  localparam int unsigned TMR_MAX     = (SETUP_CYCLES > HALF_CYCLES) ? SETUP_CYCLES : HALF_CYCLES;
  localparam int unsigned TMR_W       = $clog2(TMR_MAX + 1);
  localparam int unsigned TXN_CYCLES  = txn_cycles(SETUP_CYCLES, HALF_CYCLES);
  localparam int unsigned CONV_CYCLES = CONV_HALVES * HALF_CYCLES;

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_SETUP = TMR_W'(SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_HALF  = TMR_W'(HALF_CYCLES - 1);

  if (SETUP_CYCLES == 0 || HALF_CYCLES == 0 ||
      SAMPLE_CYCLES <= TXN_CYCLES + CONV_CYCLES) begin : g_period_check
    $error("adc_serial_reader: SAMPLE_CYCLES too short for transaction plus conversion");
  end
  if (VREF_TENTHS < VREF_TENTHS_MIN || VREF_TENTHS > VREF_TENTHS_MAX) begin : g_vref_check
    $error("adc_serial_reader: VREF_TENTHS out of range 1..99");
  end

  state_t            state, state_next;
  logic [PCNT_W-1:0] pcnt;
  logic              tick;
  logic [TMR_W-1:0]  tmr, tmr_next;
  logic [3:0]        halves, halves_next;
  logic              cs_n, cs_n_next;
  logic              sclk, sclk_next;
  logic              capture, split_start, split_done, load_out;
  logic [7:0]        shreg;
  logic [6:0]        tenths;
  logic [3:0]        quot, rem;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) pcnt <= '0;
    else if (pcnt == PCNT_LAST) pcnt <= '0;
    else pcnt <= pcnt + PCNT_W'(1);
  end

  assign tick = (pcnt == PCNT_LAST);

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) state <= S_WAIT;
    else state <= state_next;
  end

  always_comb begin
    state_next  = state;
    tmr_next    = tmr;
    halves_next = halves;
    cs_n_next   = 1'b1;
    sclk_next   = 1'b0;
    capture     = 1'b0;
    split_start = 1'b0;
    load_out    = 1'b0;
    case (state)
      S_WAIT: begin
        if (tick) begin
          state_next = S_SETUP;
          tmr_next   = TMR_SETUP;
          cs_n_next  = 1'b0;
        end
      end
      S_SETUP: begin
        cs_n_next = 1'b0;
        if (tmr == '0) begin
          state_next  = S_SHIFT;
          tmr_next    = TMR_HALF;
          halves_next = 4'd15;
        end else begin
          tmr_next = tmr - TMR_W'(1);
        end
      end
      S_SHIFT: begin
        cs_n_next = 1'b0;
        sclk_next = sclk;
        if (tmr != '0) begin
          tmr_next = tmr - TMR_W'(1);
        end else if (halves == '0) begin
          state_next = S_CALC;
          cs_n_next  = 1'b1;
          sclk_next  = 1'b0;
        end else begin
          // Odd half counts are low phases; toggling out of one is a rising edge.
          tmr_next    = TMR_HALF;
          halves_next = halves - 4'd1;
          sclk_next   = ~sclk;
          capture     = ~sclk;
        end
      end
      S_CALC: begin
        split_start = 1'b1;
        state_next  = S_SPLIT;
      end
      S_SPLIT: begin
        if (split_done) begin
          state_next = S_DONE;
          load_out   = 1'b1;
        end
      end
      S_DONE:  state_next = S_WAIT;
      default: state_next = S_WAIT;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      tmr       <= '0;
      halves    <= '0;
      cs_n      <= 1'b1;
      sclk      <= 1'b0;
      shreg     <= '0;
      o_code    <= '0;
      o_vol_int <= '0;
      o_vol_dec <= '0;
      o_valid   <= 1'b0;
    end else begin
      tmr     <= tmr_next;
      halves  <= halves_next;
      cs_n    <= cs_n_next;
      sclk    <= sclk_next;
      o_valid <= load_out;
      if (capture) shreg <= {shreg[6:0], adc.ADC_DATA};
      if (load_out) begin
        o_code    <= shreg;
        o_vol_int <= quot;
        o_vol_dec <= rem;
      end
    end
  end

  // Rounded scaling; the 15-bit product cannot overflow for VREF_TENTHS <= 99.
  assign tenths = 7'((15'(shreg) * 15'(VREF_TENTHS) + 15'd128) >> 8);

  adc_tenths_split u_split (
    .clk    (CLK_50M),
    .rst_n  (RST_N),
    .start  (split_start),
    .tenths (tenths),
    .quot   (quot),
    .rem    (rem),
    .done   (split_done)
  );

  assign adc.ADC_CS_N = cs_n;
  assign adc.ADC_CLK  = sclk;

endmodule

// File: tb/tb_adc_serial_reader.sv
// Directed bench for adc_serial_reader: ADC pin model, bus timing monitor and digit checks.
module tb_adc_serial_reader;
  import adc_pkg::*;

  localparam int unsigned SAMPLE = 400;
  localparam int unsigned SETUP  = 4;
  localparam int unsigned HALF   = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adc_serial_reader_if bus ();
  adc_serial_reader_if bus33 ();

  logic [7:0] code, code33;
  logic [3:0] vint, vdec, vint33, vdec33;
  logic       valid, valid33;

  adc_serial_reader #(
    .SAMPLE_CYCLES(SAMPLE), .SETUP_CYCLES(SETUP), .HALF_CYCLES(HALF), .VREF_TENTHS(50)
  ) dut (
    .CLK_50M(clk), .RST_N(rst_n), .adc(bus),
    .o_code(code), .o_vol_int(vint), .o_vol_dec(vdec), .o_valid(valid)
  );

  adc_serial_reader #(
    .SAMPLE_CYCLES(SAMPLE), .SETUP_CYCLES(SETUP), .HALF_CYCLES(HALF), .VREF_TENTHS(33)
  ) dut33 (
    .CLK_50M(clk), .RST_N(rst_n), .adc(bus33),
    .o_code(code33), .o_vol_int(vint33), .o_vol_dec(vdec33), .o_valid(valid33)
  );

  assign bus33.ADC_DATA = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ADC model: word loaded on CS fall, next bit presented after each ADC_CLK fall.
  logic [7:0] adc_word = 8'h00;
  logic [7:0] model_sr = 8'h00;
  logic       m_prev_cs = 1'b1;
  logic       m_prev_sclk = 1'b0;
  assign bus.ADC_DATA = model_sr[7];

  always @(negedge clk) begin
    if (m_prev_cs && !bus.ADC_CS_N) model_sr <= adc_word;
    else if (m_prev_sclk && !bus.ADC_CLK && !bus.ADC_CS_N) model_sr <= {model_sr[6:0], 1'b0};
    m_prev_cs   <= bus.ADC_CS_N;
    m_prev_sclk <= bus.ADC_CLK;
  end

  // Bus timing and output-hold monitor.
  int          since_fall = 0, rises = 0, high_cnt = 0;
  int          idle_viol = 0, hold_viol = 0, n33 = 0;
  logic        in_txn = 1'b0, prev_cs = 1'b1, prev_sclk = 1'b0;
  logic [15:0] prev_out = 16'h0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_txn = 1'b0;
    end else begin
      if (bus.ADC_CS_N && bus.ADC_CLK) idle_viol++;
      if (!valid && {code, vint, vdec} != prev_out) hold_viol++;
      since_fall++;
      if (prev_cs && !bus.ADC_CS_N) begin
        in_txn = 1'b1;
        since_fall = 0;
        rises = 0;
      end
      if (bus.ADC_CLK) begin
        if (!prev_sclk) begin
          high_cnt = 1;
          if (in_txn && !bus.ADC_CS_N) begin
            rises++;
            if (rises == 1) check("first_rise_delay", 32'(since_fall), SETUP + HALF);
          end
        end else begin
          high_cnt++;
        end
      end else if (prev_sclk && in_txn) begin
        check("high_phase_len", 32'(high_cnt), HALF);
      end
      if (in_txn && !prev_cs && bus.ADC_CS_N) begin
        check("rises_per_txn", 32'(rises), 8);
        in_txn = 1'b0;
      end
    end
    if (valid33) n33++;
    prev_cs   = bus.ADC_CS_N;
    prev_sclk = bus.ADC_CLK;
    prev_out  = {code, vint, vdec};
  end

  task automatic run_txn(input logic [7:0] word, input logic [3:0] exp_int,
                         input logic [3:0] exp_dec, output int gap);
    adc_word = word;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!valid && gap < 2 * SAMPLE);
    check("valid_seen", 32'(valid), 1);
    check("code", 32'(code), 32'(word));
    check("vol_int", 32'(vint), 32'(exp_int));
    check("vol_dec", 32'(vdec), 32'(exp_dec));
    @(negedge clk);
    check("valid_one_cycle", 32'(valid), 0);
  endtask

  initial begin
    int gap;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(bus.ADC_CS_N), 1);
    check("rst_sclk", 32'(bus.ADC_CLK), 0);
    check("rst_code", 32'(code), 0);
    check("rst_int", 32'(vint), 0);
    check("rst_dec", 32'(vdec), 0);
    check("rst_valid", 32'(valid), 0);
    #2 rst_n = 1'b1;

    run_txn(8'hFF, 4'd5, 4'd0, gap);
    run_txn(8'h80, 4'd2, 4'd5, gap);

    // Abort a 0xAA read during bit 4 with an asynchronous reset.
    adc_word = 8'hAA;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (bus.ADC_CS_N && gap < 2 * SAMPLE);
    check("cs_fall_seen", 32'(bus.ADC_CS_N), 0);
    repeat (22) @(negedge clk);
    check("pre_rst_sclk_high", 32'(bus.ADC_CLK), 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs_n", 32'(bus.ADC_CS_N), 1);
    check("abort_sclk", 32'(bus.ADC_CLK), 0);
    check("abort_code", 32'(code), 0);
    check("abort_int", 32'(vint), 0);
    check("abort_dec", 32'(vdec), 0);
    check("abort_valid", 32'(valid), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    run_txn(8'hAA, 4'd3, 4'd3, gap);
    run_txn(8'h33, 4'd1, 4'd0, gap);
    run_txn(8'h00, 4'd0, 4'd0, gap);

    for (int i = 0; i < 6; i++) begin
      run_txn(8'h33, 4'd1, 4'd0, gap);
      if (i > 0) check("valid_period", 32'(gap + 1), SAMPLE);
    end

    check("sclk_low_when_cs_high", 32'(idle_viol), 0);
    check("outputs_held", 32'(hold_viol), 0);
    check("vref33_seen", 32'(n33 != 0), 1);
    check("vref33_code", 32'(code33), 32'hFF);
    check("vref33_int", 32'(vint33), 3);
    check("vref33_dec", 32'(vdec33), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_serial_reader.md
Name: adc_serial_reader

Overview:
- Serial-ADC front end for the voltage-display path. Periodically reads one 8-bit sample from a TLC549-class serial ADC (chip select, serial clock, serial data out), MSB first.
- Scales the sample to tenths of a volt, splits it into an integer digit and a tenths digit, and holds them stable for the display driver's digit inputs.
- Sits between the board ADC pins and the segment display module.

Parameters:
- SAMPLE_CYCLES, 50_000, period between transaction starts in CLK_50M cycles (1 ms).
- SETUP_CYCLES, 100, ADC_CS_N low to first ADC_CLK rise (2 us).
- HALF_CYCLES, 25, ADC_CLK half period (1 MHz serial clock).
- VREF_TENTHS, 50, full-scale reference in tenths of a volt (5.0 V); legal range 1..99.

Ports:
- CLK_50M  in  1  system clock, 50 MHz
- RST_N  in  1  asynchronous active-low reset
- ADC_DATA  in  1  serial data from ADC, MSB first
- ADC_CS_N  out  1  ADC chip select, active low
- ADC_CLK  out  1  ADC serial clock
- o_code  out  8  last raw sample
- o_vol_int  out  4  integer volts digit, 0..9
- o_vol_dec  out  4  tenths digit, 0..9
- o_valid  out  1  one-cycle pulse when outputs update

Behaviour:
- Clock and reset: one clock, CLK_50M. RST_N is asynchronous and active low.
- Reset values: ADC_CS_N=1, ADC_CLK=0, o_code=0, o_vol_int=0, o_vol_dec=0, o_valid=0. The FSM enters S_WAIT and the period counter is cleared.
- Period counter: free-running, 0..SAMPLE_CYCLES-1, then wraps. The wrap cycle is the start tick. It is ignored unless the FSM is in S_WAIT.
- S_WAIT: ADC_CS_N=1, ADC_CLK=0. On the start tick, go to S_SETUP and drive ADC_CS_N=0 from the next cycle.
- S_SETUP: hold ADC_CS_N=0, ADC_CLK=0 for exactly SETUP_CYCLES cycles, then go to S_SHIFT.
- S_SHIFT: 8 bit periods of 2*HALF_CYCLES cycles each.
  - ADC_CLK is low for the first HALF_CYCLES cycles of a bit, high for the second.
  - ADC_DATA is captured into the shift register on the cycle ADC_CLK goes 0->1. The first capture is the MSB.
  - After the high phase of bit 7, drive ADC_CLK=0 and ADC_CS_N=1, and go to S_CALC.
  - Exactly 8 ADC_CLK rising edges per transaction.
- S_CALC (1 cycle): tenths = (code*VREF_TENTHS + 128) >> 8, using a 15-bit product and a 7-bit result.
- S_SPLIT: iterative subtract-10 on tenths, at most 9 iterations, one per cycle. The quotient gives the int digit and the remainder gives the dec digit.
- S_DONE (1 cycle):
  - Register o_code, o_vol_int and o_vol_dec.
  - Pulse o_valid=1 for this cycle only.
  - Return to S_WAIT.
- Output stability: outputs change only in S_DONE and hold otherwise.
- Latency: start tick to o_valid = 1 + SETUP_CYCLES + 16*HALF_CYCLES + 1 + split cycles + 1.
- Integrity: SAMPLE_CYCLES must exceed the worst-case transaction length plus 17 us of ADC conversion time. An elaboration-time check fails otherwise. A start tick arriving outside S_WAIT is dropped, never queued.
- Reset mid-transaction: ADC_CS_N returns to 1 and ADC_CLK to 0 immediately. The partial sample is discarded and the previous outputs clear to reset values.
- Boundary values: code 0x00 gives 0.0. Code 0xFF gives VREF_TENTHS exactly (5.0 by default). ADC_DATA is treated as stable; no input synchronizer is required.

Decomposition:
- Shared package adc_pkg holds:
  - FSM state encoding: S_WAIT, S_SETUP, S_SHIFT, S_CALC, S_SPLIT, S_DONE.
  - Default timing constants.
  - A VREF_TENTHS range-check constant.
- One sub-module, adc_tenths_split: a sequential divide-by-10 taking a 7-bit tenths value and a start strobe, returning 4-bit quotient, 4-bit remainder and a done flag.

Test Plan (SAMPLE_CYCLES=400, SETUP_CYCLES=4, HALF_CYCLES=2 for simulation):
- ADC model returns 0xFF -> o_code=0xFF, o_vol_int=5, o_vol_dec=0, one o_valid pulse.
- ADC model returns 0x80 -> tenths 25, so o_vol_int=2, o_vol_dec=5; 0x33 -> int 1, dec 0; 0x00 -> int 0, dec 0.
- Bus timing check per transaction:
  - Exactly 8 ADC_CLK rises while ADC_CS_N=0.
  - First rise exactly SETUP_CYCLES+HALF_CYCLES cycles after ADC_CS_N falls.
  - Each high phase lasts HALF_CYCLES cycles.
  - ADC_CLK=0 whenever ADC_CS_N=1.
- Assert RST_N low during bit 4 of a 0xAA read -> ADC_CS_N=1 and ADC_CLK=0 asynchronously, outputs=0. The next transaction reads 0xAA correctly (int 3, dec 3).
- Steady run of 5 periods -> o_valid pulses exactly 400 cycles apart and outputs are held between pulses.
- VREF_TENTHS=33, code 0xFF -> o_vol_int=3, o_vol_dec=3.
